beat_source: RTL and testbench

//  Upstream producer for the single-register valid/ready pipeline stage. It feeds that stage's

---
 rtl/bus_hs_pkg.sv | 14 +
 rtl/beat_source_down_counter.sv | 29 ++
 rtl/beat_source.sv | 140 ++++++++++++++
 tb/tb_beat_source.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_hs_pkg.sv
// Shared definitions for the BusHandshakes chain: source FSM state encoding and
// the default beat data width.
package bus_hs_pkg;

  localparam int DEFAULT_DATA_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } src_state_t;

endpackage

// File: rtl/beat_source_down_counter.sv
// Loadable down counter with a zero flag; used as the idle-gap timer in
// beat_source.
module down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // load wins over dec so a fresh gap always starts from its full value
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/beat_source.sv
// Burst generator feeding a valid/ready stage: counting beat data from a seed,
// optional idle gaps between accepted beats, and a done pulse at burst end.
import bus_hs_pkg::*;

module beat_source #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LEN_W  = 4,
  parameter int GAP_W  = 3
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic [DATA_W-1:0] seed,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  src_state_t        state, state_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  sent, sent_n;
  logic [GAP_W-1:0]  gap_q, gap_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n;
  logic              busy_n;
  logic              done_n;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              accept;

  assign accept = valid_out && ready_in;

  // The timer is loaded with gap-1 so that reaching zero marks the last idle cycle.
  down_counter #(
    .W(GAP_W)
  ) u_gap_timer (
    .clk      (sys_clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (gap_q - GAP_ONE),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n  = state;
    len_n    = len_q;
    sent_n   = sent;
    gap_n    = gap_q;
    data_n   = data_out;
    valid_n  = valid_out;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && (burst_len != '0)) begin
          len_n   = burst_len;
          gap_n   = gap_cycles;
          sent_n  = '0;
          data_n  = seed;
          valid_n = 1'b1;
          state_n = ST_SEND;
        end
      end

      ST_SEND: begin
        if (accept) begin
          if (sent == (len_q - LEN_ONE)) begin
            valid_n = 1'b0;
            state_n = ST_DONE;
          end else begin
            sent_n = sent + LEN_ONE;
            if (gap_q == '0) begin
              data_n = data_out + DATA_ONE;
            end else begin
              valid_n  = 1'b0;
              cnt_load = 1'b1;
              state_n  = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (cnt_zero) begin
          valid_n = 1'b1;
          data_n  = data_out + DATA_ONE;
          state_n = ST_SEND;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_DONE);
  end

  // All outputs are registered from next-state values, so ready_in never reaches valid_out combinationally.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      sent      <= '0;
      gap_q     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      sent      <= sent_n;
      gap_q     <= gap_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_beat_source.sv
// Directed bench for beat_source: bursts, wrap, gaps, backpressure, ignored
// starts, reset mid-burst and a randomized-ready sink scoreboard.
module tb_beat_source;

  logic       sys_clk;
  logic       rst;
  logic       start;
  logic [3:0] burst_len;
  logic [2:0] gap_cycles;
  logic [2:0] seed;
  logic       ready_in;
  logic       valid_out;
  logic [2:0] data_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  beat_source #(
    .DATA_W(3),
    .LEN_W (4),
    .GAP_W (3)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .gap_cycles (gap_cycles),
    .seed       (seed),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven 1ns later.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input int len, input int gap, input int sd);
    start      = 1'b1;
    burst_len  = 4'(len);
    gap_cycles = 3'(gap);
    seed       = 3'(sd);
    tick();
    start = 1'b0;
  endtask

  // Full burst with ready held high: beats, exact idle gaps, done pulse, return to idle.
  task automatic runBurst(input string tag, input int len, input int gap, input int sd);
    ready_in = 1'b1;
    applyStimulus(len, gap, sd);
    for (int b = 0; b < len; b++) begin
      checkOutput({tag, "_valid"}, int'(valid_out), 1);
      checkOutput({tag, "_data"}, int'(data_out), (sd + b) % 8);
      tick();
      if (b < len - 1) begin
        for (int g = 0; g < gap; g++) begin
          checkOutput({tag, "_gap_valid"}, int'(valid_out), 0);
          checkOutput({tag, "_gap_busy"}, int'(busy), 1);
          tick();
        end
      end
    end
    checkOutput({tag, "_done"}, int'(done), 1);
    checkOutput({tag, "_done_valid"}, int'(valid_out), 0);
    checkOutput({tag, "_done_busy"}, int'(busy), 1);
    tick();
    checkOutput({tag, "_idle_done"}, int'(done), 0);
    checkOutput({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    burst_len  = '0;
    gap_cycles = '0;
    seed       = '0;
    ready_in   = 1'b0;
    tick();
    tick();
    checkOutput("reset_valid", int'(valid_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_data", int'(data_out), 0);
    rst = 1'b0;
    tick();

    runBurst("basic", 4, 0, 2);
    runBurst("wrap", 5, 0, 6);
    runBurst("gaps", 3, 2, 1);
    runBurst("gap1", 2, 1, 7);

    // Backpressure on beat 2 for three cycles
    ready_in = 1'b1;
    applyStimulus(3, 0, 1);
    checkOutput("bp_beat1", int'(data_out), 1);
    tick();
    ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_hold_valid", int'(valid_out), 1);
      checkOutput("bp_hold_data", int'(data_out), 2);
      tick();
    end
    ready_in = 1'b1;
    checkOutput("bp_release_data", int'(data_out), 2);
    tick();
    checkOutput("bp_beat3_valid", int'(valid_out), 1);
    checkOutput("bp_beat3_data", int'(data_out), 3);
    tick();
    checkOutput("bp_done", int'(done), 1);
    tick();
    checkOutput("bp_idle", int'(busy), 0);

    // Zero-length request is ignored
    applyStimulus(0, 0, 5);
    checkOutput("len0_valid", int'(valid_out), 0);
    checkOutput("len0_busy", int'(busy), 0);
    tick();
    checkOutput("len0_done", int'(done), 0);

    // Start during SEND and during DONE must not restart the burst
    ready_in = 1'b0;
    applyStimulus(3, 1, 4);
    applyStimulus(7, 0, 0);
    checkOutput("restart_send_data", int'(data_out), 4);
    ready_in = 1'b1;
    tick();
    checkOutput("restart_gap_valid", int'(valid_out), 0);
    tick();
    checkOutput("restart_beat2", int'(data_out), 5);
    tick();
    tick();
    checkOutput("restart_beat3", int'(data_out), 6);
    tick();
    checkOutput("restart_in_done", int'(done), 1);
    applyStimulus(2, 0, 0);
    checkOutput("restart_done_valid", int'(valid_out), 0);
    checkOutput("restart_done_busy", int'(busy), 0);
    tick();
    checkOutput("restart_done_still_idle", int'(valid_out), 0);

    // Reset mid-burst abandons the burst without a done pulse
    applyStimulus(8, 0, 3);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_valid", int'(valid_out), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_data", int'(data_out), 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("midrst_no_beats", int'(valid_out), 0);
      checkOutput("midrst_no_done", int'(done), 0);
    end

    // Random-ready sink scoreboard: accepted beats must be seed, seed+1, ... with stable holds
    begin
      int     accepted;
      int     cycles;
      logic   prev_valid;
      logic   prev_ready;
      logic [2:0] prev_data;
      bit     saw_done;
      accepted   = 0;
      cycles     = 0;
      saw_done   = 1'b0;
      ready_in   = 1'b0;
      applyStimulus(10, 1, 5);
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = '0;
      while (!saw_done && cycles < 300) begin
        if (prev_valid && !prev_ready) begin
          checkOutput("chain_hold_valid", int'(valid_out), 1);
          checkOutput("chain_hold_data", int'(data_out), int'(prev_data));
        end
        ready_in = 1'($urandom_range(0, 1));
        if (valid_out && ready_in) begin
          checkOutput("chain_beat", int'(data_out), (5 + accepted) % 8);
          accepted++;
        end
        prev_valid = valid_out;
        prev_ready = ready_in;
        prev_data  = data_out;
        tick();
        cycles++;
        if (done) saw_done = 1'b1;
      end
      checkOutput("chain_finished", int'(saw_done), 1);
      checkOutput("chain_count", accepted, 10);
      tick();
      checkOutput("chain_idle", int'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
